// File: rtl/vga_sync_generator_if.sv
// Bus between the horizontal counter and the VGA sync generator.
// The slave side is the generator; the master side drives the counter and observes the sync outputs.
interface vga_sync_generator_if;
  logic        enable_V_Counter;
  logic [15:0] H_Count_Value;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        line_start;
  logic        frame_start;
  logic [9:0]  V_Count_Value;
  logic        locked;
  logic        sync_err;

  modport master (
    output enable_V_Counter, H_Count_Value,
    input  hsync, vsync, video_on, pixel_x, pixel_y,
           line_start, frame_start, V_Count_Value, locked, sync_err
  );

  modport slave (
    input  enable_V_Counter, H_Count_Value,
    output hsync, vsync, video_on, pixel_x, pixel_y,
           line_start, frame_start, V_Count_Value, locked, sync_err
  );
endinterface

// File: rtl/vga_sync_generator.sv
// Vertical counter and registered VGA timing outputs, locked to an external 800-count
// horizontal counter. Stage 1 aligns h/v and tracks lock; stage 2 decodes the outputs.
module vga_sync_generator #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic                 clk_25MHz,
  input  logic                 rst_n,
  vga_sync_generator_if.slave  bus
);

  localparam logic [15:0] H_TOTAL    = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [15:0] H_VIS      = 16'(H_VISIBLE);
  localparam logic [15:0] HS_START   = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END     = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] h_q;
  logic [9:0]  v_q, v_d;
  logic        err_d;
  logic        valid_s, bad_s, run_s;

  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic [9:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [9:0]  v_count_q, v_count_d;
  logic        locked_q, locked_d, sync_err_q;

  assign valid_s = bus.enable_V_Counter && (bus.H_Count_Value == 16'd0);
  // An out-of-range count never coincides with H == 0, so valid_s and bad_s are disjoint.
  assign bad_s   = (bus.enable_V_Counter && (bus.H_Count_Value != 16'd0)) ||
                   (!bus.enable_V_Counter && (bus.H_Count_Value == 16'd0)) ||
                   (bus.H_Count_Value >= H_TOTAL);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    err_d   = 1'b0;
    case (state_q)
      SEEK: begin
        v_d = 10'd0;
        if (valid_s) begin
          state_d = RUN;
        end else begin
          state_d = SEEK;
        end
      end
      RUN: begin
        if (bad_s) begin
          state_d = SEEK;
          v_d     = 10'd0;
          err_d   = 1'b1;
        end else if (valid_s) begin
          v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
          v_d = v_q;
        end
      end
      default: begin
        state_d = SEEK;
        v_d     = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEEK;
      h_q     <= 16'd0;
      v_q     <= 10'd0;
    end else begin
      state_q <= state_d;
      h_q     <= bus.H_Count_Value;
      v_q     <= v_d;
    end
  end

  assign run_s = (state_q == RUN);

  always_comb begin
    hsync_d       = ~SYNC_ACTIVE;
    vsync_d       = ~SYNC_ACTIVE;
    video_on_d    = 1'b0;
    pixel_x_d     = 10'd0;
    pixel_y_d     = 10'd0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    v_count_d     = 10'd0;
    locked_d      = 1'b0;
    if (run_s) begin
      hsync_d       = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_d    = (h_q < H_VIS) && (v_q < V_VIS);
      pixel_x_d     = video_on_d ? h_q[9:0] : 10'd0;
      pixel_y_d     = video_on_d ? v_q : 10'd0;
      line_start_d  = (h_q == 16'd0);
      frame_start_d = (h_q == 16'd0) && (v_q == 10'd0);
      v_count_d     = v_q;
      locked_d      = 1'b1;
    end else begin
      locked_d      = 1'b0;
    end
  end

  // sync_err is registered from the live input check, so it leads locked by one cycle.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      v_count_q     <= 10'd0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      v_count_q     <= v_count_d;
      locked_q      <= locked_d;
      sync_err_q    <= err_d;
    end
  end

  assign bus.hsync         = hsync_q;
  assign bus.vsync         = vsync_q;
  assign bus.video_on      = video_on_q;
  assign bus.pixel_x       = pixel_x_q;
  assign bus.pixel_y       = pixel_y_q;
  assign bus.line_start    = line_start_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.V_Count_Value = v_count_q;
  assign bus.locked        = locked_q;
  assign bus.sync_err      = sync_err_q;

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Consumes the free-running 800-count horizontal pixel counter and its end-of-line enable. Maintains the 525-line vertical counter and produces registered VGA hsync/vsync, video_on, visible pixel coordinates and frame/line markers for the pixel-colour stage. The block checks that the horizontal count and the line enable stay consistent, and blanks its output until it is locked to the horizontal phase.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch; H_TOTAL = sum = 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch; V_TOTAL = sum = 525
- SYNC_ACTIVE, 0, sync pulse level (0 = active-low)

Ports:
- clk_25MHz  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- enable_V_Counter  in  1  line-advance strobe, high for exactly one cycle, coincident with H_Count_Value == 0
- H_Count_Value  in  16  horizontal count, 0..H_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high inside the visible window
- pixel_x  out  10  H position when video_on, else 0
- pixel_y  out  10  V position when video_on, else 0
- line_start  out  1  one-cycle pulse at H = 0 of every line (RUN only)
- frame_start  out  1  one-cycle pulse at H = 0, V = 0 (RUN only)
- V_Count_Value  out  10  current line, 0..V_TOTAL-1
- locked  out  1  stage-2 outputs derived from the RUN state
- sync_err  out  1  one-cycle pulse when a phase mismatch is detected

## Operation
- Stage 1 registers H_Count_Value into h_d and updates the vertical counter v on the same edge, so h_d and v are aligned. This stage also holds the FSM.
- FSM SEEK (reset state):
  - v is held at 0.
  - On enable_V_Counter = 1 with H_Count_Value = 0: go to RUN and set v = 0.
  - Any other input: stay in SEEK.
- FSM RUN:
  - On enable_V_Counter = 1 with H_Count_Value = 0: v <= (v == V_TOTAL-1) ? 0 : v + 1.
  - On enable_V_Counter = 1 with H_Count_Value ≠ 0, or H_Count_Value = 0 with enable_V_Counter = 0: go to SEEK, set v = 0, pulse sync_err for one cycle.
  - H_Count_Value ≥ H_TOTAL: treat as a mismatch (same action as above).
- Stage 2 registers all outputs from (h_d, v, state). Syncs are inactive and all other outputs are 0 unless stage 1 was in RUN.
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT ≤ h_d < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise !SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - video_on = (h_d < H_VISIBLE) && (v < V_VISIBLE).
  - pixel_x / pixel_y = h_d[9:0] / v when video_on, else 0.
  - line_start = (h_d == 0); frame_start = (h_d == 0 && v == 0).
  - V_Count_Value = v; locked = (state was RUN).
- All comparisons are unsigned. h_d is compared at its full 16 bits and truncated to 10 bits only for pixel_x.

## Timing
- Latency: outputs reflect the H_Count_Value sampled 2 rising edges earlier. v advances 1 edge after the enable, so v and h_d are coherent at stage 2.
- Reset values:
  - Stage 1: state SEEK, h_d = 0, v = 0.
  - Stage 2: hsync = vsync = !SYNC_ACTIVE; video_on, pixel_x, pixel_y, line_start, frame_start, V_Count_Value, locked and sync_err all 0.
- Reset asserted mid-frame: all registers return to reset values immediately (asynchronously). After release, the block re-locks on the next line enable.
- Lock after reset or error: locked rises 2 cycles after the first valid enable. The first locked output is frame_start = 1 (line 0, pixel 0).
- sync_err rises 1 cycle after the offending input sample. locked falls 1 cycle after sync_err.
- Frame wrap: line 524 → 0 at the enable. frame_start follows 1 cycle after that v update.

## Test plan
- Reset, then drive a horizontal-counter model starting at H = 300 → outputs blanked and locked = 0 until the first enable at H = 0. frame_start = 1 exactly 2 cycles later, with pixel_x = pixel_y = 0 and video_on = 1.
- Free-run one full line → hsync low exactly for 96 cycles (input H 656..751, seen 2 cycles later); video_on high for 640 cycles; pixel_x steps 0..639.
- Free-run 525 lines → vsync low exactly on lines 490–491; V_Count_Value wraps 524 → 0; one frame_start per 420000 cycles; 525 line_start pulses.
- Inject enable_V_Counter = 1 at H = 37 while locked → sync_err pulses once; locked drops; outputs blanked; re-lock at the next H = 0 enable with v = 0.
- Drive H_Count_Value = 900 while locked → treated as a mismatch: sync_err pulse, return to SEEK.
- Assert rst_n low at line 250, H = 400 → all outputs take reset values without waiting for a clock edge; normal lock resumes after release.
